// File: rtl/pipe_stage_buf.sv
// Elastic in-order stage buffer carrying an opaque payload between pipeline stages.
// Optional backpressure counter enabled with `define PIPE_STALL_CNT_EN.
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rp;
    logic [PW-1:0]    wp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // ready depends on registered occupancy only, never on out_ready
    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rp] : '0;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push)
                wp <= (wp == LAST) ? '0 : wp + 1'b1;
            if (pop)
                rp <= (rp == LAST) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // storage is not cleared; the out_data mask keeps bubbles clean
    always_ff @(posedge clk) begin
        if (push && !reset && !flush)
            mem[wp] <= in_data;
    end

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage buffer: the successor to the fixed-field, stall-vector-driven stage registers (EX/MEM, MEM/WB) of the 5-stage core. It carries an opaque WIDTH-bit payload (the parent packs d1/d2/rn/pc/except/cp0 fields into it) through a DEPTH-entry in-order buffer. A per-link valid/ready handshake replaces the global stall vector, and synchronous flush/bubble semantics are kept. One instance sits between each pair of pipeline stages.

## Interface
- WIDTH, 32: payload width in bits, 1..512.
- DEPTH, 2: number of buffer entries, 1..8. A value of 2 or more is needed for full throughput.
- CW, $clog2(DEPTH+1): occupancy width. Derived; do not override.
- clk  in  1  clock. All logic updates on the rising edge.
- reset  in  1  synchronous, active-high. Priority over everything else.
- flush  in  1  synchronous kill of all held entries (exception/eret redirect).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  buffer can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  WIDTH  head payload. Zero whenever out_valid=0.
- count  out  CW  number of entries held.
- stall_cycles  out  32  backpressure cycle counter. Present only with PIPE_STALL_CNT_EN.

## Operation
- Storage: DEPTH×WIDTH entry array, read pointer rp and write pointer wp (each mod DEPTH), occupancy count.
- Push occurs when in_valid && in_ready. in_data is written at wp, wp advances and wraps from DEPTH-1 to 0.
- Pop occurs when out_valid && out_ready. rp advances and wraps the same way.
- count next = count + push − pop. Simultaneous push and pop leave count unchanged.
- in_ready = (count != DEPTH). It is a function of registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- out_data = entry[rp] when out_valid, else all zeros. This is the same bubble contract as the legacy stage registers.
- When full, in_ready=0, so no push occurs even if a pop happens in the same cycle. The freed slot becomes visible the next cycle.
- When empty, no pop is possible. A push becomes visible the next cycle; there is no fall-through path.
- Flush is synchronous:
  - Next cycle: count=0, rp=wp=0, out_valid=0.
  - An input offered in the flush cycle is discarded, even if in_ready=1. Upstream treats it as killed.
  - A pop handshake in the flush cycle still counts as consumed from the downstream view.
- Reset performs the same actions as flush, and additionally clears stall_cycles.
- Payload storage contents need not be cleared. The zero-masking of out_data guarantees that bubbles are clean.
- Order is strictly FIFO. There is no reordering and no duplication.

## Timing
- Reset values: out_valid=0, out_data=0, count=0, in_ready=1, stall_cycles=0.
- Latency: a payload pushed at edge N appears on out_data and out_valid after edge N, i.e. it is consumable in cycle N+1.
- Throughput:
  - DEPTH≥2: one item per cycle under continuous out_ready=1.
  - DEPTH=1: one item every 2 cycles, because in_ready falls while the single entry is held.
- Reset asserted mid-stream: everything is lost. Outputs hold their reset values from the next cycle until reset deasserts. The first push is accepted in the first cycle with reset=0.
- Precedence when reset, flush and handshakes occur together: reset > flush > push/pop.

## Configuration
- PIPE_STALL_CNT_EN defined:
  - stall_cycles port and a 32-bit counter exist.
  - The counter increments on each cycle with out_valid && !out_ready and saturates at 0xFFFFFFFF.
  - It is cleared by reset only, not by flush.
- Not defined: no port, no counter, no extra flops. Buffer behaviour is otherwise identical.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 → out_valid=0, out_data=0, count=0, in_ready=1, and nothing emitted after release.
- Streaming, DEPTH=2, out_ready=1: push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles → each appears one cycle later, in_ready stays 1, count stays 1.
- Backpressure, DEPTH=2:
  - Set out_ready=0, push 0x11 and 0x22, then offer 0x33 → count=2, in_ready=0, 0x33 held upstream.
  - Raise out_ready → output sequence 0x11, 0x22, 0x33 with no gaps after the first.
- Flush: with 2 entries held and in_valid=1 (0x55) in the flush cycle → next cycle count=0, out_valid=0, out_data=0, and 0x55 never emitted.
- Wrap-around, DEPTH=3: push 0..19 with pseudo-random out_ready → output is exactly 0..19 in order, count never exceeds 3, and no pushes occur while in_ready=0.
- PIPE_STALL_CNT_EN: hold one entry with out_ready=0 for 5 cycles → stall_cycles=5. Flush → stall_cycles still 5. Reset → 0.
